simon_param_core: RTL and testbench

Parametrised iterative SIMON block cipher core covering every SIMON variant (2N-bit block, M-word key, T rounds, z-sequence Co). The core expands the key once into a stored round-key file. It then encrypts or decrypts any number of blocks, one round per clock, using the newData/ldData/doneData/readData handshake of the existing fixed-size cores. It is the drop-in successor to the single-variant SIMON cores in the cipher datapath.

---
 rtl/simon_pkg.sv | 50 +++++
 rtl/simon_keysched.sv | 79 +++++++
 rtl/simon_param_core.sv | 145 ++++++++++++++
 tb/tb_simon_param_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z-sequences, width-generic rotates, round function,
// FSM state type and the table of legal (N,M,T) variants.
package simon_pkg;

   // Leftmost character of each z string is z[0], stored at bit 61.
   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
   localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
   localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
   localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

   typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} state_t;

   function automatic logic [61:0] z_seq(input int co);
      case (co)
         1:       return Z1;
         2:       return Z2;
         3:       return Z3;
         4:       return Z4;
         default: return Z0;
      endcase
   endfunction

   function automatic logic [63:0] width_mask(input int n);
      return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
   endfunction

   // Words live zero-extended in a 64-bit container; n is the real word size.
   function automatic logic [63:0] rol(input logic [63:0] v, input int n, input int s);
      return ((v << s) | (v >> (n - s))) & width_mask(n);
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] v, input int n, input int s);
      return rol(v, n, n - s);
   endfunction

   function automatic logic [63:0] simon_f(input logic [63:0] v, input int n);
      return (rol(v, n, 1) & rol(v, n, 8)) ^ rol(v, n, 2);
   endfunction

   function automatic bit simon_legal(input int n, input int m, input int t);
      return (n == 16 && m == 4 && t == 32) ||
             (n == 24 && m == 3 && t == 36) || (n == 24 && m == 4 && t == 36) ||
             (n == 32 && m == 3 && t == 42) || (n == 32 && m == 4 && t == 44) ||
             (n == 48 && m == 2 && t == 52) || (n == 48 && m == 3 && t == 54) ||
             (n == 64 && m == 2 && t == 68) || (n == 64 && m == 3 && t == 69) ||
             (n == 64 && m == 4 && t == 72);
   endfunction

endpackage

// File: rtl/simon_keysched.sv
// SIMON key expansion: holds the T-entry round-key file, generates one key per
// cycle after a start pulse, and serves a registered read port to the datapath.
module simon_keysched
   import simon_pkg::*;
#(
   parameter int N  = 64,
   parameter int M  = 4,
   parameter int T  = 72,
   parameter int Co = 4
) (
   input  logic                 clk,
   input  logic                 R,
   input  logic                 start,
   input  logic [M*N-1:0]       key,
   input  logic [$clog2(T)-1:0] rd_idx,
   output logic                 ldKey,
   output logic                 doneKey,
   output logic                 last,
   output logic [N-1:0]         rk_rd
);
   localparam int IW = $clog2(T);
   localparam logic [61:0] ZSEL = z_seq(Co);

   logic [N-1:0]  rk [T];
   logic          active;
   logic [IW-1:0] cnt;
   logic [5:0]    zb;
   logic [IW-1:0] i_next, i_last, i_new;
   logic [N-1:0]  t_rot, t_mix, t_fin, new_rk;

   assign i_next = cnt + IW'(1);
   assign i_last = cnt + IW'(M - 1);
   assign i_new  = cnt + IW'(M);
   assign last   = active && (cnt == IW'(T - M));

   assign t_rot  = N'(ror(64'(rk[i_last]), N, 3));
   assign t_mix  = (M == 4) ? (t_rot ^ rk[i_next]) : t_rot;
   assign t_fin  = t_mix ^ N'(ror(64'(t_mix), N, 1));
   assign new_rk = ~rk[cnt] ^ t_fin ^ N'(ZSEL[zb]) ^ N'(3);

   // The extra cycle with cnt == T-M publishes doneKey once the file is complete.
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         ldKey   <= 1'b0;
         doneKey <= 1'b0;
         active  <= 1'b0;
         cnt     <= '0;
         zb      <= 6'd61;
      end else begin
         ldKey <= 1'b0;
         if (start) begin
            ldKey   <= 1'b1;
            doneKey <= 1'b0;
            active  <= 1'b1;
            cnt     <= '0;
            zb      <= 6'd61;
         end else if (active) begin
            if (last) begin
               active  <= 1'b0;
               doneKey <= 1'b1;
            end else begin
               cnt <= cnt + IW'(1);
               zb  <= (zb == 6'd0) ? 6'd61 : zb - 6'd1;
            end
         end
      end
   end

   // The key file carries no reset; doneKey alone says whether it is valid.
   always_ff @(posedge clk) begin
      if (start) begin
         for (int k = 0; k < M; k++) rk[k] <= key[k*N +: N];
      end else if (active && !last) begin
         rk[i_new] <= new_rk;
      end
      rk_rd <= rk[rd_idx];
   end

endmodule

// File: rtl/simon_param_core.sv
// Iterative SIMON core for every standard variant, one round per clock.
// Define SIMON_DEC_EN to build the decryption path; otherwise enc_dec is ignored.
module simon_param_core
   import simon_pkg::*;
#(
   parameter int N  = 64,
   parameter int M  = 4,
   parameter int T  = 72,
   parameter int Co = 4
) (
   input  logic             clk,
   input  logic             R,
   input  logic             newKey,
   input  logic [M*N-1:0]   key,
   output logic             ldKey,
   output logic             doneKey,
   input  logic             newData,
   input  logic             enc_dec,
   input  logic [2*N-1:0]   plain,
   output logic             ldData,
   output logic             doneData,
   input  logic             readData,
   output logic [2*N-1:0]   cipher
);
   localparam int IW = $clog2(T);

   if (!simon_legal(N, M, T)) begin : g_bad_variant
      $error("simon_param_core: (N,M,T) is not a standard SIMON variant");
   end
   if (Co < 0 || Co > 4) begin : g_bad_co
      $error("simon_param_core: Co must select z0..z4");
   end

   state_t        state;
   logic [N-1:0]  x, y, nx, ny, rk_rd;
   logic [IW-1:0] rnd;
   logic [IW:0]   left;
   logic          first;
   logic          key_last;
   logic          key_start;

   assign key_start = (state == IDLE) && newKey;

   simon_keysched #(.N(N), .M(M), .T(T), .Co(Co)) u_keysched (
      .clk     (clk),
      .R       (R),
      .start   (key_start),
      .key     (key),
      .rd_idx  (rnd),
      .ldKey   (ldKey),
      .doneKey (doneKey),
      .last    (key_last),
      .rk_rd   (rk_rd)
   );

`ifdef SIMON_DEC_EN
   logic dec;
   always_comb begin
      nx = y ^ N'(simon_f(64'(x), N)) ^ rk_rd;
      ny = x;
      if (dec) begin
         nx = y;
         ny = x ^ N'(simon_f(64'(y), N)) ^ rk_rd;
      end
   end
`else
   logic enc_dec_unused;
   assign enc_dec_unused = enc_dec;
   always_comb begin
      nx = y ^ N'(simon_f(64'(x), N)) ^ rk_rd;
      ny = x;
   end
`endif

   // The round-key read is registered, so the first RUN cycle only primes it.
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state    <= IDLE;
         ldData   <= 1'b0;
         doneData <= 1'b0;
         cipher   <= '0;
         x        <= '0;
         y        <= '0;
         rnd      <= '0;
         left     <= '0;
         first    <= 1'b0;
`ifdef SIMON_DEC_EN
         dec      <= 1'b0;
`endif
      end else begin
         ldData <= 1'b0;
         case (state)
            IDLE: begin
               if (newKey) begin
                  state <= KEYEXP;
               end else if (newData && doneKey) begin
                  x      <= plain[2*N-1:N];
                  y      <= plain[N-1:0];
                  ldData <= 1'b1;
                  first  <= 1'b1;
                  left   <= (IW+1)'(T);
`ifdef SIMON_DEC_EN
                  dec    <= !enc_dec;
                  rnd    <= enc_dec ? '0 : IW'(T - 1);
`else
                  rnd    <= '0;
`endif
                  state  <= RUN;
               end
            end
            KEYEXP: begin
               if (key_last) state <= IDLE;
            end
            RUN: begin
`ifdef SIMON_DEC_EN
               if (dec) begin
                  if (rnd != '0) rnd <= rnd - IW'(1);
               end else
`endif
               if (rnd != IW'(T - 1)) rnd <= rnd + IW'(1);
               if (first) begin
                  first <= 1'b0;
               end else begin
                  x    <= nx;
                  y    <= ny;
                  left <= left - (IW+1)'(1);
                  if (left == (IW+1)'(1)) begin
                     cipher   <= {nx, ny};
                     doneData <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               if (readData) begin
                  doneData <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simon_param_core.sv
// Directed bench for simon_param_core: SIMON128/256 and SIMON32/64 instances
// checked against published test vectors, handshake timing and reset behaviour.
module tb_simon_param_core;

   localparam int AN = 64, AM = 4, AT = 72;
   localparam int BN = 16, BM = 4, BT = 32;
   localparam logic [255:0] A_KEY = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] A_PT  = 128'h74206e69206d6f6f6d69732061207369;
   localparam logic [127:0] A_CT  = 128'h8d2b5579afc8a3a03bf72a87efe7b868;
   localparam logic [63:0]  B_KEY = 64'h1918111009080100;
   localparam logic [31:0]  B_PT  = 32'h65656877;
   localparam logic [31:0]  B_CT  = 32'hc69be9bb;
`ifdef SIMON_DEC_EN
   localparam bit DEC_ON = 1'b1;
`else
   localparam bit DEC_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic r;
   logic a_new_key, a_ld_key, a_done_key, a_new_data, a_enc_dec, a_ld_data, a_done_data, a_read_data;
   logic [AM*AN-1:0] a_key;
   logic [2*AN-1:0]  a_plain, a_cipher;
   logic b_new_key, b_ld_key, b_done_key, b_new_data, b_enc_dec, b_ld_data, b_done_data, b_read_data;
   logic [BM*BN-1:0] b_key;
   logic [2*BN-1:0]  b_plain, b_cipher;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   simon_param_core #(.N(AN), .M(AM), .T(AT), .Co(4)) dut_a (
      .clk(clk), .R(r), .newKey(a_new_key), .key(a_key), .ldKey(a_ld_key), .doneKey(a_done_key),
      .newData(a_new_data), .enc_dec(a_enc_dec), .plain(a_plain), .ldData(a_ld_data),
      .doneData(a_done_data), .readData(a_read_data), .cipher(a_cipher)
   );

   simon_param_core #(.N(BN), .M(BM), .T(BT), .Co(0)) dut_b (
      .clk(clk), .R(r), .newKey(b_new_key), .key(b_key), .ldKey(b_ld_key), .doneKey(b_done_key),
      .newData(b_new_data), .enc_dec(b_enc_dec), .plain(b_plain), .ldData(b_ld_data),
      .doneData(b_done_data), .readData(b_read_data), .cipher(b_cipher)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] b_in(input int j);
      return (DEC_ON && (j % 2 == 1)) ? B_CT : B_PT;
   endfunction

   function automatic logic [31:0] b_exp(input int j);
      return (DEC_ON && (j % 2 == 1)) ? B_PT : B_CT;
   endfunction

   task automatic test_reset;
      r = 1'b1;
      {a_new_key, a_new_data, a_enc_dec, a_read_data} = 4'b0010;
      {b_new_key, b_new_data, b_enc_dec, b_read_data} = 4'b0010;
      a_key = '0; a_plain = '0; b_key = '0; b_plain = '0;
      tick; tick;
      checks++;
      if ({a_ld_key, a_done_key, a_ld_data, a_done_data} !== 4'b0) begin
         errors++; $display("[TB] FAIL reset_a_flags: got %b expected 0000", {a_ld_key, a_done_key, a_ld_data, a_done_data});
      end
      checks++;
      if (a_cipher !== '0) begin errors++; $display("[TB] FAIL reset_a_cipher: got %h expected 0", a_cipher); end
      checks++;
      if ({b_ld_key, b_done_key, b_ld_data, b_done_data} !== 4'b0) begin
         errors++; $display("[TB] FAIL reset_b_flags: got %b expected 0000", {b_ld_key, b_done_key, b_ld_data, b_done_data});
      end
      checks++;
      if (b_cipher !== '0) begin errors++; $display("[TB] FAIL reset_b_cipher: got %h expected 0", b_cipher); end
      r = 1'b0;
      tick;
   endtask

   task automatic test_data_without_key;
      bit seen = 1'b0;
      a_new_data = 1'b1; b_new_data = 1'b1;
      repeat (10) begin tick; if (a_ld_data || b_ld_data) seen = 1'b1; end
      a_new_data = 1'b0; b_new_data = 1'b0;
      checks++;
      if (seen !== 1'b0) begin errors++; $display("[TB] FAIL nokey_ld_data: got %b expected 0", seen); end
   endtask

   task automatic test_key_priority_128;
      int  cyc = 0;
      bit  held = 1'b0;
      a_key = A_KEY; a_plain = A_PT; a_enc_dec = 1'b1;
      a_new_key = 1'b1; a_new_data = 1'b1;
      tick;
      checks++;
      if (a_ld_key !== 1'b1) begin errors++; $display("[TB] FAIL prio_ld_key: got %b expected 1", a_ld_key); end
      checks++;
      if (a_ld_data !== 1'b0) begin errors++; $display("[TB] FAIL prio_ld_data: got %b expected 0", a_ld_data); end
      a_new_key = 1'b0;
      while (!a_done_key && cyc < 200) begin tick; cyc++; if (a_ld_data) held = 1'b1; end
      checks++;
      if (cyc != AT - AM + 1) begin errors++; $display("[TB] FAIL key_latency_128: got %0d expected %0d", cyc, AT - AM + 1); end
      checks++;
      if (held !== 1'b0) begin errors++; $display("[TB] FAIL data_held_off: got %b expected 0", held); end
      tick;
      checks++;
      if (a_ld_data !== 1'b1) begin errors++; $display("[TB] FAIL ld_data_after_key: got %b expected 1", a_ld_data); end
      a_new_data = 1'b0;
      cyc = 0;
      while (!a_done_data && cyc < 200) begin tick; cyc++; end
      checks++;
      if (cyc != AT + 1) begin errors++; $display("[TB] FAIL enc_latency_128: got %0d expected %0d", cyc, AT + 1); end
      checks++;
      if (a_cipher !== A_CT) begin errors++; $display("[TB] FAIL enc_128: got %h expected %h", a_cipher, A_CT); end
   endtask

   task automatic test_read_delay_128;
      bit stable = 1'b1;
      bit high = 1'b1;
      repeat (20) begin
         tick;
         if (a_cipher !== A_CT) stable = 1'b0;
         if (a_done_data !== 1'b1) high = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("[TB] FAIL hold_cipher: got %b expected 1", stable); end
      checks++;
      if (high !== 1'b1) begin errors++; $display("[TB] FAIL hold_done_data: got %b expected 1", high); end
      a_read_data = 1'b1;
      tick;
      a_read_data = 1'b0;
      checks++;
      if (a_done_data !== 1'b0) begin errors++; $display("[TB] FAIL read_clears_done: got %b expected 0", a_done_data); end
   endtask

   task automatic test_enc_dec_128;
      int cyc = 0;
      logic [127:0] exp_out;
      a_plain   = DEC_ON ? A_CT : A_PT;
      exp_out   = DEC_ON ? A_PT : A_CT;
      a_enc_dec = 1'b0;
      a_new_data = 1'b1;
      tick;
      a_new_data = 1'b0;
      while (!a_done_data && cyc < 200) begin tick; cyc++; end
      checks++;
      if (cyc != AT + 1) begin errors++; $display("[TB] FAIL encdec0_latency: got %0d expected %0d", cyc, AT + 1); end
      checks++;
      if (a_cipher !== exp_out) begin errors++; $display("[TB] FAIL encdec0_result: got %h expected %h", a_cipher, exp_out); end
      a_read_data = 1'b1;
      tick;
      a_read_data = 1'b0;
   endtask

   task automatic test_back_to_back_32;
      int cyc = 0;
      int last_ld = -1;
      int ld_cnt = 0;
      int done_cnt = 0;
      bit key_drop = 1'b0;
      b_key = B_KEY;
      b_new_key = 1'b1;
      tick;
      checks++;
      if (b_ld_key !== 1'b1) begin errors++; $display("[TB] FAIL ld_key_32: got %b expected 1", b_ld_key); end
      b_new_key = 1'b0;
      while (!b_done_key && cyc < 200) begin tick; cyc++; end
      checks++;
      if (cyc != BT - BM + 1) begin errors++; $display("[TB] FAIL key_latency_32: got %0d expected %0d", cyc, BT - BM + 1); end
      b_plain = b_in(0); b_enc_dec = !(DEC_ON && 1'b0);
      b_new_data = 1'b1; b_read_data = 1'b1;
      cyc = 0;
      while (done_cnt < 5 && cyc < 1000) begin
         tick; cyc++;
         if (b_done_key !== 1'b1) key_drop = 1'b1;
         if (b_ld_data) begin
            if (last_ld >= 0) begin
               checks++;
               if (cyc - last_ld != BT + 3) begin
                  errors++; $display("[TB] FAIL b2b_period_%0d: got %0d expected %0d", ld_cnt, cyc - last_ld, BT + 3);
               end
            end
            last_ld = cyc;
            ld_cnt++;
            b_plain = b_in(ld_cnt);
            b_enc_dec = !(DEC_ON && (ld_cnt % 2 == 1));
            if (ld_cnt == 5) b_new_data = 1'b0;
         end
         if (b_done_data) begin
            checks++;
            if (b_cipher !== b_exp(done_cnt)) begin
               errors++; $display("[TB] FAIL b2b_block_%0d: got %h expected %h", done_cnt, b_cipher, b_exp(done_cnt));
            end
            done_cnt++;
         end
      end
      checks++;
      if (done_cnt != 5) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 5", done_cnt); end
      checks++;
      if (key_drop !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_key_drop: got %b expected 0", key_drop); end
      tick;
      b_read_data = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_run_32;
      bit seen = 1'b0;
      b_plain = B_PT; b_enc_dec = 1'b1;
      b_new_data = 1'b1;
      tick;
      b_new_data = 1'b0;
      repeat (11) tick;
      r = 1'b1;
      tick;
      checks++;
      if ({b_ld_key, b_done_key, b_ld_data, b_done_data} !== 4'b0) begin
         errors++; $display("[TB] FAIL midrun_flags: got %b expected 0000", {b_ld_key, b_done_key, b_ld_data, b_done_data});
      end
      checks++;
      if (b_cipher !== '0) begin errors++; $display("[TB] FAIL midrun_cipher: got %h expected 0", b_cipher); end
      r = 1'b0;
      tick;
      b_new_data = 1'b1;
      repeat (10) begin tick; if (b_ld_data) seen = 1'b1; end
      b_new_data = 1'b0;
      checks++;
      if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrun_no_reload: got %b expected 0", seen); end
      checks++;
      if (b_done_key !== 1'b0) begin errors++; $display("[TB] FAIL midrun_done_key: got %b expected 0", b_done_key); end
   endtask

   initial begin
      test_reset;
      test_data_without_key;
      test_key_priority_128;
      test_read_delay_128;
      test_enc_dec_128;
      test_back_to_back_32;
      test_reset_mid_run_32;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
